// File: rtl/screen_sequencer.sv
// Frame-rate screen/pick-ball sequencer: samples the keycode once per VS falling
// edge and steps the title/aim/release/game-over machine feeding color_mapper.
//
// state   | meaning
// --------+-------------------------------------------------------------
// TITLE   | title screen, pick ball parked at its initial position
// AIM     | W/S move the pick ball vertically, Space launches it
// RELEASE | pick ball travels right until it reaches PICK_X_MAX
// OVER    | game over, Enter or timeout returns to TITLE
module screen_sequencer #(
   parameter int PICK_X_INIT    = 310,
   parameter int PICK_Y_INIT    = 240,
   parameter int PICK_Y_MIN     = 140,
   parameter int PICK_Y_MAX     = 340,
   parameter int PICK_X_MAX     = 630,
   parameter int STEP           = 2,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       VS,
   input  logic [7:0] keycode,
   output logic [2:0] currScreen,
   output logic [9:0] PickX,
   output logic [9:0] PickY,
   output logic       frame_tick
);

   typedef enum logic [2:0] {
      TITLE   = 3'b000,
      AIM     = 3'b001,
      RELEASE = 3'b010,
      OVER    = 3'b111
   } state_t;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_ESC   = 8'h29;

   localparam logic [9:0]  X_INIT   = 10'(PICK_X_INIT);
   localparam logic [9:0]  Y_INIT   = 10'(PICK_Y_INIT);
   localparam logic [9:0]  Y_MIN    = 10'(PICK_Y_MIN);
   localparam logic [9:0]  Y_MAX    = 10'(PICK_Y_MAX);
   localparam logic [9:0]  X_MAX    = 10'(PICK_X_MAX);
   localparam logic [9:0]  STEP10   = 10'(STEP);
   localparam logic [10:0] STEP11   = 11'(STEP);
   localparam logic [10:0] Y_MIN11  = 11'(PICK_Y_MIN);
   localparam logic [10:0] Y_MAX11  = 11'(PICK_Y_MAX);
   localparam logic [10:0] X_MAX11  = 11'(PICK_X_MAX);
   localparam logic [9:0]  CNT_LAST = 10'(TIMEOUT_FRAMES - 1);

   state_t     state;
   state_t     state_n;
   logic       vs_d;
   logic [7:0] key_prev;
   logic [9:0] frame_cnt;
   logic [9:0] frame_cnt_n;
   logic [9:0] pick_x;
   logic [9:0] pick_x_n;
   logic [9:0] pick_y;
   logic [9:0] pick_y_n;

   logic       new_esc;
   logic       new_enter;
   logic       new_space;
   logic [9:0] y_dec;
   logic [9:0] y_inc;
   logic [9:0] x_adv;
   logic       x_end;

   assign new_esc   = (keycode == KEY_ESC)   && (key_prev != KEY_ESC);
   assign new_enter = (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
   assign new_space = (keycode == KEY_SPACE) && (key_prev != KEY_SPACE);

   // Bounds are compared in 11 bits so the step can never wrap past zero or 1023.
   always_comb begin
      y_dec = Y_MIN;
      y_inc = Y_MAX;
      x_adv = X_MAX;
      x_end = 1'b1;
      if ({1'b0, pick_y} >= (Y_MIN11 + STEP11)) begin
         y_dec = pick_y - STEP10;
      end
      if (({1'b0, pick_y} + STEP11) <= Y_MAX11) begin
         y_inc = pick_y + STEP10;
      end
      if (({1'b0, pick_x} + STEP11) < X_MAX11) begin
         x_adv = pick_x + STEP10;
         x_end = 1'b0;
      end
   end

   always_comb begin
      state_n     = state;
      pick_x_n    = pick_x;
      pick_y_n    = pick_y;
      frame_cnt_n = frame_cnt;
      if (new_esc) begin
         state_n     = TITLE;
         pick_x_n    = X_INIT;
         pick_y_n    = Y_INIT;
         frame_cnt_n = 10'd0;
      end else begin
         case (state)
            TITLE: begin
               pick_x_n = X_INIT;
               pick_y_n = Y_INIT;
               if (new_enter) begin
                  state_n = AIM;
               end
            end
            AIM: begin
               if (new_space) begin
                  state_n = RELEASE;
               end else if (keycode == KEY_W) begin
                  pick_y_n = y_dec;
               end else if (keycode == KEY_S) begin
                  pick_y_n = y_inc;
               end
            end
            RELEASE: begin
               pick_x_n = x_adv;
               if (x_end) begin
                  state_n     = OVER;
                  frame_cnt_n = 10'd0;
               end
            end
            OVER: begin
               if (new_enter || (frame_cnt == CNT_LAST)) begin
                  state_n     = TITLE;
                  pick_x_n    = X_INIT;
                  pick_y_n    = Y_INIT;
                  frame_cnt_n = 10'd0;
               end else begin
                  frame_cnt_n = frame_cnt + 10'd1;
               end
            end
            default: begin
               state_n     = TITLE;
               pick_x_n    = X_INIT;
               pick_y_n    = Y_INIT;
               frame_cnt_n = 10'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         vs_d       <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_d       <= VS;
         frame_tick <= vs_d & ~VS;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= TITLE;
         pick_x    <= X_INIT;
         pick_y    <= Y_INIT;
         key_prev  <= 8'h00;
         frame_cnt <= 10'd0;
      end else if (frame_tick) begin
         state     <= state_n;
         pick_x    <= pick_x_n;
         pick_y    <= pick_y_n;
         key_prev  <= keycode;
         frame_cnt <= frame_cnt_n;
      end
   end

   assign currScreen = state;
   assign PickX      = pick_x;
   assign PickY      = pick_y;

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Frame-rate game controller that owns the screen state and pick-ball position consumed by the color mapper. It samples the keyboard keycode once per video frame, steps a four-state screen machine (title, aim, release, game over), and drives `currScreen`, `PickX` and `PickY` as registered outputs. It sits between the USB keyboard interface and `color_mapper`, clocked by the pixel-domain clock.

## Interface

Parameters:
- `PICK_X_INIT`, default 310: PickX value at reset and on return to title.
- `PICK_Y_INIT`, default 240: PickY value at reset and on return to title.
- `PICK_Y_MIN`, default 140: lower saturation bound for PickY.
- `PICK_Y_MAX`, default 340: upper saturation bound for PickY.
- `PICK_X_MAX`, default 630: PickX end-of-travel; reaching it ends the release.
- `STEP`, default 2: pixels moved per frame.
- `TIMEOUT_FRAMES`, default 600: frames spent in game over before auto-return (1..1023).

Ports (one clock; reset is asynchronous and active-high):
- `CLK`, in, 1: system clock; all state updates on its rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `VS`, in, 1: vertical sync level from the VGA controller, synchronous to `CLK`.
- `keycode`, in, 8: current USB HID keycode; 0x00 means no key.
- `currScreen`, out, 3: screen select: 000 title, 001 aim, 010 release, 111 game over.
- `PickX`, out, 10: pick-ball centre X.
- `PickY`, out, 10: pick-ball centre Y.
- `frame_tick`, out, 1: one-cycle pulse per frame.

## Operation

- Frame tick: `vs_d` registers `VS`. `frame_tick` is registered to `vs_d & ~VS` (the falling edge of VS). All state, position and key-history updates occur only on edges where `frame_tick` = 1.
- Key press detection: `key_prev` holds the keycode sampled at the previous tick. A "new press of K" means `keycode` == K and `key_prev` != K at a tick. `key_prev` is updated on every tick.
- Keys: Enter 0x28, Space 0x2C, W 0x1A, S 0x16, Escape 0x29.
- States and encoding:
  - TITLE=000.
  - AIM=001.
  - RELEASE=010.
  - OVER=111.
- Transitions, evaluated per tick in priority order:
  - A new Escape press in any state goes to TITLE and reloads PickX/PickY to their INIT values. This has the highest priority.
  - TITLE: a new Enter press goes to AIM. Positions are held at INIT.
  - AIM:
    - W held (level, not edge): PickY = max(PickY-STEP, PICK_Y_MIN).
    - S held: PickY = min(PickY+STEP, PICK_Y_MAX).
    - A new Space press goes to RELEASE. PickY is frozen on that tick with no move.
  - RELEASE: PickX = PickX+STEP each tick. If PickX+STEP >= PICK_X_MAX, PickX = PICK_X_MAX and the state goes to OVER on the same edge. All keys except Escape are ignored.
  - OVER: `frame_cnt` (10 bits) increments each tick.
    - If a new Enter press occurs, or `frame_cnt` == TIMEOUT_FRAMES-1, go to TITLE, reload positions and clear `frame_cnt`.
    - Enter takes precedence over the timeout; both cases lead to the same result.
- `frame_cnt` is cleared on every entry to OVER.
- Arithmetic: position math is done in 11 bits so subtraction cannot wrap. Results are clamped before truncation to 10 bits. PickX never exceeds PICK_X_MAX, and PickY never leaves [PICK_Y_MIN, PICK_Y_MAX].
- Illegal state encodings (011, 100, 101, 110) go to TITLE with positions reloaded on the next tick.

## Timing

- Reset values (asserted asynchronously, immediately on `Reset`=1):
  - `currScreen`=000, `PickX`=PICK_X_INIT, `PickY`=PICK_Y_INIT, `frame_tick`=0.
  - `vs_d`=0, `key_prev`=0x00, `frame_cnt`=0.
- Reset during any state or mid-release discards all progress. The first tick after release cannot be spurious, because `vs_d`=0.
- Latency:
  - Edge k samples VS=0 with `vs_d`=1, so `frame_tick`=1 after edge k.
  - Edge k+1 updates state and positions, so outputs change exactly 2 edges after VS falls.
- `frame_tick` is high for exactly one cycle per VS falling edge. A VS held low produces no further ticks.
- All outputs are registered and glitch-free. Between ticks they are stable for the whole frame.
- A keycode that changes and returns between two ticks is invisible; only tick-sampled values count.

## Test plan

- Reset and idle: pulse Reset mid-simulation while in RELEASE, then run 5 frames with keycode=0x00. Expect currScreen=000, PickX=310, PickY=240 immediately and throughout; frame_tick pulses once per frame, 1 cycle wide, 1 cycle after each VS fall.
- Start and aim saturation: Enter for 1 frame gives AIM. Hold W for 60 frames: PickY goes 238, 236, … and stops at 140. Hold S for 120 frames: PickY stops at 340. Holding Enter across 3 frames from TITLE produces a single transition only.
- Release travel: from AIM with PickY=200, press Space. Expect currScreen=010 on the next tick. PickX then advances by 2 per frame: 312, 314, …, 628, then 630 with currScreen=111 on that same tick (160 ticks total). PickY stays at 200.
- Game-over timeout: with TIMEOUT_FRAMES=4, after entering OVER apply 4 ticks with no key. Expect currScreen=000 on the 4th tick, with PickX=310 and PickY=240.
- Escape priority: in AIM holding S, switch keycode to 0x29. Expect TITLE and positions reloaded on that tick. Holding Escape for further frames causes no change; a subsequent Enter after a key release gives AIM.
